im_cache_dm: RTL and testbench

- Parametrised direct-mapped, read-only instruction cache with multi-word lines.
- Sits between the fetch stage and a slow instruction memory that uses a req/rdy handshake.
- Hits are combinational, so data is valid in the same cycle the address is presented.
- A miss runs an explicit refill FSM that fetches the whole line one word at a time, then resumes hitting.

---
 rtl/im_cache_dm.sv | 165 ++++++++++++++++
 tb/tb_im_cache_dm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/im_cache_dm.sv
// Direct-mapped read-only instruction cache with multi-word lines and a word-serial refill FSM.
// Optional hit/miss counters are built when IM_CACHE_STATS_EN is defined.
module im_cache_dm #(
   parameter int unsigned IDX_BITS  = 2,
   parameter int unsigned WOFF_BITS = 1,
   localparam int unsigned TAG_BITS = 30 - IDX_BITS - WOFF_BITS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic [31:0] addr,
   input  logic        flush,
   output logic        hit,
   output logic [31:0] data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_rdy,
   input  logic [31:0] mem_data
`ifdef IM_CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned LINES = 1 << IDX_BITS;
   localparam int unsigned WORDS = 1 << WOFF_BITS;
   localparam int unsigned CNT_W = (WOFF_BITS > 0) ? WOFF_BITS : 1;

   typedef enum logic [0:0] {StIdle, StRefill} state_e;

   state_e                         state_q, state_d;
   logic [LINES-1:0]               valid_q, valid_d;
   logic [TAG_BITS-1:0]            tag_q [LINES];
   logic [TAG_BITS-1:0]            tag_d [LINES];
   logic [WORDS-1:0][31:0]         line_q [LINES];
   logic [WORDS-1:0][31:0]         line_d [LINES];
   logic [TAG_BITS-1:0]            rtag_q, rtag_d;
   logic [IDX_BITS-1:0]            ridx_q, ridx_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;

   logic [CNT_W-1:0]    woff;
   logic [IDX_BITS-1:0] idx;
   logic [TAG_BITS-1:0] tag;
   logic [31:0]         refill_addr;
   logic                last_word;
   logic                miss_start;
   logic                unused_addr;

   assign woff        = CNT_W'((addr >> 2) & 32'(WORDS - 1));
   assign idx         = addr[2+WOFF_BITS +: IDX_BITS];
   assign tag         = addr[31 -: TAG_BITS];
   assign unused_addr = ^addr[1:0];

   // With one-word lines cnt stays 0, so its term contributes nothing.
   assign refill_addr = (32'(rtag_q) << (2 + WOFF_BITS + IDX_BITS))
                      | (32'(ridx_q) << (2 + WOFF_BITS))
                      | ((32'(cnt_q) & 32'(WORDS - 1)) << 2);
   assign last_word   = (cnt_q == CNT_W'(WORDS - 1));

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      line_d     = line_q;
      rtag_d     = rtag_q;
      ridx_d     = ridx_q;
      cnt_d      = cnt_q;
      hit        = 1'b0;
      data       = 32'h0;
      mem_req    = 1'b0;
      mem_addr   = 32'h0;
      miss_start = 1'b0;

      // Outputs are forced quiet while reset is asserted.
      if (!reset) begin
         unique case (state_q)
            StIdle: begin
               hit = rd & valid_q[idx] & (tag_q[idx] == tag);
               if (hit) begin
                  data = line_q[idx][woff];
               end
               if (rd && !hit && !flush) begin
                  miss_start   = 1'b1;
                  rtag_d       = tag;
                  ridx_d       = idx;
                  cnt_d        = '0;
                  valid_d[idx] = 1'b0;
                  state_d      = StRefill;
               end
            end
            StRefill: begin
               mem_req  = 1'b1;
               mem_addr = refill_addr;
               if (mem_rdy) begin
                  line_d[ridx_q][cnt_q] = mem_data;
                  cnt_d                 = cnt_q + 1'b1;
                  if (last_word) begin
                     valid_d[ridx_q] = 1'b1;
                     tag_d[ridx_q]   = rtag_q;
                     state_d         = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // Flush overrides everything, including a completing refill.
      if (flush) begin
         valid_d = '0;
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tags, data and refill latches are qualified by valid/state and need no reset.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      line_q <= line_d;
      rtag_q <= rtag_d;
      ridx_q <= ridx_d;
   end

`ifdef IM_CACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (hit) begin
         hit_count_d = hit_count_q + 32'd1;
      end
      if (miss_start) begin
         miss_count_d = miss_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count_q  <= 32'h0;
         miss_count_q <= 32'h0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_im_cache_dm.sv
// Directed bench for im_cache_dm with a fixed 3-cycle-per-word memory responder.
// Counter checks are included when IM_CACHE_STATS_EN is defined.
module tb_im_cache_dm;

   logic        clk;
   logic        reset;
   logic        rd;
   logic [31:0] addr;
   logic        flush;
   logic        hit;
   logic [31:0] data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rdy;
   logic [31:0] mem_data;
`ifdef IM_CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int          n_total;
   int          n_bad;
   int          wcnt;
   int          cyc;
   logic [31:0] addr_log[$];

   im_cache_dm dut (
      .clk      (clk),
      .reset    (reset),
      .rd       (rd),
      .addr     (addr),
      .flush    (flush),
      .hit      (hit),
      .data     (data),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_rdy  (mem_rdy),
      .mem_data (mem_data)
`ifdef IM_CACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns {16'hC0DE, addr[15:0]} on the third negedge of a held request.
   initial begin
      mem_rdy  = 1'b0;
      mem_data = 32'h0;
      wcnt     = 0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            wcnt++;
            if (wcnt == 3) begin
               mem_rdy  = 1'b1;
               mem_data = {16'hC0DE, mem_addr[15:0]};
               addr_log.push_back(mem_addr);
               wcnt     = 0;
            end else begin
               mem_rdy = 1'b0;
            end
         end else begin
            mem_rdy = 1'b0;
            wcnt    = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hit(output int n);
      n = 0;
      while (!hit && n < 100) begin
         step();
         n++;
      end
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset   = 1'b1;
      rd      = 1'b0;
      addr    = 32'h0;
      flush   = 1'b0;
      step();
      rd   = 1'b1;
      addr = 32'h10;
      #1;
      chk("reset_hit", {31'h0, hit}, 32'h0);
      chk("reset_data", data, 32'h0);
      chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      step();

      // Cold miss at 0x10
      reset = 1'b0;
      #1;
      chk("cold_miss_hit", {31'h0, hit}, 32'h0);
      addr_log.delete();
      wait_hit(cyc);
      chk("cold_latency", 32'(cyc), 32'd7);
      chk("cold_log_n", 32'(addr_log.size()), 32'd2);
      if (addr_log.size() >= 2) begin
         chk("cold_addr0", addr_log[0], 32'h10);
         chk("cold_addr1", addr_log[1], 32'h14);
      end
      chk("cold_data", data, 32'hC0DE0010);
      chk("cold_mem_req_idle", {31'h0, mem_req}, 32'h0);
      addr = 32'h14;
      #1;
      chk("hit_0x14", {31'h0, hit}, 32'h1);
      chk("data_0x14", data, 32'hC0DE0014);
      rd = 1'b0;
      #1;
      chk("no_rd_hit", {31'h0, hit}, 32'h0);
      chk("no_rd_data", data, 32'h0);

      // Conflict: 0x50 shares idx 2 with 0x10
      rd   = 1'b1;
      addr = 32'h50;
      #1;
      chk("conflict_miss", {31'h0, hit}, 32'h0);
      addr_log.delete();
      wait_hit(cyc);
      chk("conflict_latency", 32'(cyc), 32'd7);
      if (addr_log.size() >= 2) begin
         chk("conflict_addr0", addr_log[0], 32'h50);
         chk("conflict_addr1", addr_log[1], 32'h54);
      end else begin
         chk("conflict_log_n", 32'(addr_log.size()), 32'd2);
      end
      chk("conflict_data", data, 32'hC0DE0050);
      addr = 32'h10;
      #1;
      chk("evicted_miss", {31'h0, hit}, 32'h0);
      wait_hit(cyc);
      chk("refetch_data", data, 32'hC0DE0010);

      // Flush after the first word of a refill
      addr = 32'h50;
      addr_log.delete();
      cyc  = 0;
      while (addr_log.size() < 1 && cyc < 50) begin
         step();
         cyc++;
      end
      chk("flush_first_word_seen", 32'(addr_log.size()), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("flush_mem_req_drop", {31'h0, mem_req}, 32'h0);
      chk("flush_hit", {31'h0, hit}, 32'h0);
      addr_log.delete();
      wait_hit(cyc);
      chk("flush_rerefill_latency", 32'(cyc), 32'd7);
      if (addr_log.size() >= 1) begin
         chk("flush_rerefill_word0", addr_log[0], 32'h50);
      end else begin
         chk("flush_rerefill_log_n", 32'(addr_log.size()), 32'd2);
      end
      chk("flush_rerefill_data", data, 32'hC0DE0050);

      // Reset in the middle of a refill of 0x10
      addr = 32'h10;
      #1;
      chk("pre_reset_miss", {31'h0, hit}, 32'h0);
      step();
      step();
      step();
      chk("mid_refill_req", {31'h0, mem_req}, 32'h1);
      chk("mid_refill_addr", mem_addr, 32'h10);
      reset = 1'b1;
      #1;
      chk("in_reset_mem_req", {31'h0, mem_req}, 32'h0);
      chk("in_reset_mem_addr", mem_addr, 32'h0);
      step();
      reset = 1'b0;
      addr  = 32'h50;
      #1;
      chk("post_reset_miss", {31'h0, hit}, 32'h0);
      chk("post_reset_mem_req", {31'h0, mem_req}, 32'h0);
      wait_hit(cyc);
      chk("post_reset_data", data, 32'hC0DE0050);

      // Address change during refill of 0x10 to 0x80
      addr = 32'h10;
      addr_log.delete();
      step();
      addr = 32'h80;
      cyc  = 0;
      while (mem_req && cyc < 50) begin
         step();
         cyc++;
      end
      if (addr_log.size() >= 2) begin
         chk("chg_addr0", addr_log[0], 32'h10);
         chk("chg_addr1", addr_log[1], 32'h14);
      end else begin
         chk("chg_log_n", 32'(addr_log.size()), 32'd2);
      end
      chk("chg_0x80_miss", {31'h0, hit}, 32'h0);
      step();
      chk("chg_0x80_req", {31'h0, mem_req}, 32'h1);
      chk("chg_0x80_addr", mem_addr, 32'h80);
      wait_hit(cyc);
      chk("chg_0x80_data", data, 32'hC0DE0080);
      addr = 32'h14;
      #1;
      chk("chg_0x14_data", data, 32'hC0DE0014);

`ifdef IM_CACHE_STATS_EN
      reset = 1'b1;
      rd    = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk("stats_reset_hits", hit_count, 32'h0);
      chk("stats_reset_miss", miss_count, 32'h0);
      rd   = 1'b1;
      addr = 32'h10;
      wait_hit(cyc);
      step();
      addr = 32'h14;
      step();
      rd = 1'b0;
      #1;
      chk("stats_miss", miss_count, 32'd1);
      chk("stats_hits", hit_count, 32'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("stats_clr_hits", hit_count, 32'h0);
      chk("stats_clr_miss", miss_count, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
